// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the 8-to-3 priority encoder.
//   PRIO_IN_W / PRIO_OUT_W : request vector width and index width
//   PRIO_OUT_RST           : index value held while in reset
//   prio_enc_res_t         : one encoding result (index, valid, optional multi)
// Optional feature macro: PRIO_ENC_MULTI_EN adds the multi flag to the result.
package prio_enc_pkg;

   localparam int unsigned PRIO_IN_W  = 8;
   localparam int unsigned PRIO_OUT_W = 3;

   localparam logic [PRIO_OUT_W-1:0] PRIO_OUT_RST = 3'b000;

   typedef struct packed {
      logic [PRIO_OUT_W-1:0] idx;
      logic                  valid;
`ifdef PRIO_ENC_MULTI_EN
      logic                  multi;
`endif
   } prio_enc_res_t;

endpackage

// File: rtl/priority_encoder_8to3_if.sv
// Request/result bundle for the priority encoder.
//   en    : capture enable (master -> slave)
//   in    : request vector, bit 7 highest priority (master -> slave)
//   out   : registered index of highest set bit (slave -> master)
//   valid : registered non-empty flag (slave -> master)
//   multi : registered two-or-more-bits flag, only with PRIO_ENC_MULTI_EN
interface priority_encoder_8to3_if;
   import prio_enc_pkg::*;

   logic                  en;
   logic [PRIO_IN_W-1:0]  in;
   logic [PRIO_OUT_W-1:0] out;
   logic                  valid;
`ifdef PRIO_ENC_MULTI_EN
   logic                  multi;
`endif

`ifdef PRIO_ENC_MULTI_EN
   modport master (output en, output in, input out, input valid, input multi);
   modport slave  (input en, input in, output out, output valid, output multi);
`else
   modport master (output en, output in, input out, input valid);
   modport slave  (input en, input in, output out, output valid);
`endif

endinterface

// File: rtl/priority_encoder_8to3_core.sv
// Purely combinational priority core.
//   in  : 8-bit request vector, bit 7 highest priority
//   res : index of the highest set bit, valid flag, and (with PRIO_ENC_MULTI_EN)
//         a flag for two or more bits set
module priority_encoder_8to3_core
   import prio_enc_pkg::*;
(
   input  logic [PRIO_IN_W-1:0] in,
   output prio_enc_res_t        res
);

   always_comb begin
      res.idx   = PRIO_OUT_RST;
      res.valid = 1'b0;
      // Ascending scan: later (higher) set bits overwrite lower ones.
      for (int i = 0; i < PRIO_IN_W; i++) begin
         if (in[i]) begin
            res.idx   = i[PRIO_OUT_W-1:0];
            res.valid = 1'b1;
         end
      end
`ifdef PRIO_ENC_MULTI_EN
      // Clearing the lowest set bit leaves something only if 2+ bits were set.
      res.multi = |(in & (in - PRIO_IN_W'(1)));
`endif
   end

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset; clears out/valid(/multi)
//   bus : slave side of priority_encoder_8to3_if (en, in -> out, valid[, multi])
// One clock of latency from in/en to the outputs; no combinational in->out path.
// Optional feature macro: PRIO_ENC_MULTI_EN adds the registered multi output.
module priority_encoder_8to3
   import prio_enc_pkg::*;
#(
   parameter int unsigned IN_W  = PRIO_IN_W,
   parameter int unsigned OUT_W = $clog2(IN_W)
) (
   input  logic                    clk,
   input  logic                    rst,
   priority_encoder_8to3_if.slave  bus
);

   if (IN_W != PRIO_IN_W || OUT_W != PRIO_OUT_W) begin : g_width_check
      $error("priority_encoder_8to3 supports only IN_W=8, OUT_W=3");
   end

   prio_enc_res_t res_d;
   prio_enc_res_t res_q;

   priority_encoder_8to3_core u_core (
      .in  (bus.in),
      .res (res_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q.idx   <= PRIO_OUT_RST;
         res_q.valid <= 1'b0;
`ifdef PRIO_ENC_MULTI_EN
         res_q.multi <= 1'b0;
`endif
      end else if (bus.en) begin
         res_q <= res_d;
      end
   end

   assign bus.out   = res_q.idx;
   assign bus.valid = res_q.valid;
`ifdef PRIO_ENC_MULTI_EN
   assign bus.multi = res_q.multi;
`endif

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Scoreboard bench for priority_encoder_8to3: stimulus pushes the expected
// registered result for each cycle; a monitor pops and compares after each edge.
module tb_priority_encoder_8to3;

   typedef struct {
      logic [2:0] out;
      logic       valid;
      logic       multi;
      string      name;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   priority_encoder_8to3_if bus ();

   priority_encoder_8to3 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Drive inputs now and queue the result expected after the next rising edge.
   task automatic drive(input logic e, input logic [7:0] v, input logic [2:0] o,
                        input logic vl, input logic m, input string name);
      exp_t x;
      bus.en = e;
      bus.in = v;
      x.out = o; x.valid = vl; x.multi = m; x.name = name;
      sb.push_back(x);
   endtask

   task automatic step(input logic e, input logic [7:0] v, input logic [2:0] o,
                       input logic vl, input logic m, input string name);
      @(negedge clk);
      drive(e, v, o, vl, m, name);
   endtask

   // Monitor: outputs update on the rising edge; sample 1 time unit later.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check({x.name, ".out"}, {1'b0, bus.out}, {1'b0, x.out});
         check({x.name, ".valid"}, {3'b0, bus.valid}, {3'b0, x.valid});
`ifdef PRIO_ENC_MULTI_EN
         check({x.name, ".multi"}, {3'b0, bus.multi}, {3'b0, x.multi});
`endif
      end
   end

   initial begin
      logic [7:0] walk;
      rst    = 1'b0;
      bus.en = 1'b1;
      bus.in = 8'hFF;
      // Reset asserted between edges must clear outputs at once.
      #2 rst = 1'b1;
      #1;
      check("rst_async.out", {1'b0, bus.out}, 4'h0);
      check("rst_async.valid", {3'b0, bus.valid}, 4'h0);
      // Held through edges despite en=1, in=FF.
      step(1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, "rst_hold0");
      step(1'b1, 8'hFF, 3'd0, 1'b0, 1'b0, "rst_hold1");
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1, "rst_release");

      // Walking one.
      walk = 8'h01;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, walk, 3'(i), 1'b1, 1'b0, $sformatf("walk%0d", i));
         walk = walk << 1;
      end

      // Empty, then lowest bit alone.
      step(1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "empty");
      step(1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "bit0");

      // Multiple bits set.
      step(1'b1, 8'h03, 3'd1, 1'b1, 1'b1, "in03");
      step(1'b1, 8'h0F, 3'd3, 1'b1, 1'b1, "in0F");
      step(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1, "inFF");
      step(1'b1, 8'h81, 3'd7, 1'b1, 1'b1, "in81");

      // Enable hold.
      step(1'b1, 8'h10, 3'd4, 1'b1, 1'b0, "hold_cap");
      for (int i = 0; i < 3; i++)
         step(1'b0, 8'h80, 3'd4, 1'b1, 1'b0, $sformatf("hold%0d", i));
      step(1'b1, 8'h80, 3'd7, 1'b1, 1'b0, "hold_rel");

      // Async reset mid-stream.
      step(1'b1, 8'h20, 3'd5, 1'b1, 1'b0, "mid_cap");
      @(negedge clk);
      bus.en = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst.out", {1'b0, bus.out}, 4'h0);
      check("mid_rst.valid", {3'b0, bus.valid}, 4'h0);
      #1 rst = 1'b0;
      drive(1'b0, 8'hFF, 3'd0, 1'b0, 1'b0, "mid_after");
      step(1'b1, 8'h60, 3'd6, 1'b1, 1'b1, "in60");
      step(1'b0, 8'h00, 3'd6, 1'b1, 1'b1, "in60_hold");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
